rr_mux_stream: RTL and testbench

- Parametrised successor to the combinational mux2: a CHANNELS-input, N-bit streaming multiplexer with valid/ready handshakes.
- Selection is either fair round-robin arbitration or a forced channel.
- The result is held in a single registered output stage, so latency is 1 cycle and throughput is 1 word/cycle.
- Sits between multiple producers and one shared consumer, e.g. sensor channels feeding a single display/UART path.

---
 rtl/rr_mux_stream.sv | 121 ++++++++++++
 tb/tb_rr_mux_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_stream.sv
// rtl/rr_mux_stream.sv - round-robin / forced-select streaming mux with registered output stage
module rr_mux_stream #(
    parameter int N        = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS*N-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
    input  logic                  force_en,
    input  logic [SEL_W-1:0]      force_sel,
    output logic [N-1:0]          out_data,
    output logic [SEL_W-1:0]      out_channel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
    output logic [15:0]           xfer_count
);

    localparam int CW = SEL_W + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SEL_W-1:0]       ptr;
    logic                   can_load;
    logic                   force_bad;
    logic                   grant_vld;
    logic [SEL_W-1:0]       grant_idx;
    logic [(1<<SEL_W)-1:0]  valid_pad;
    logic [CW-1:0]          idx;
    logic [N-1:0]           sel_data;

    assign out_valid = (state_q == FULL);
    assign can_load  = !out_valid || out_ready;
    assign force_bad = force_en && ({1'b0, force_sel} >= CW'(CHANNELS));

    // Pick the granted channel: forced index, or first valid channel at/after ptr
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        valid_pad = '0;
        valid_pad[CHANNELS-1:0] = in_valid;
        if (!rst && can_load) begin
            if (force_en) begin
                if (!force_bad && valid_pad[force_sel]) begin
                    grant_vld = 1'b1;
                    grant_idx = force_sel;
                end
            end else begin
                // Walk from the farthest offset down so the nearest valid channel wins last
                for (int i = CHANNELS - 1; i >= 0; i--) begin
                    idx = {1'b0, ptr} + CW'(i);
                    if (idx >= CW'(CHANNELS)) begin
                        idx = idx - CW'(CHANNELS);
                    end
                    if (valid_pad[idx[SEL_W-1:0]]) begin
                        grant_vld = 1'b1;
                        grant_idx = idx[SEL_W-1:0];
                    end
                end
            end
        end
    end

    // Decode the grant into per-channel ready and pick the granted channel's data
    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant_vld && (grant_idx == SEL_W'(c))) begin
                in_ready[c] = 1'b1;
                sel_data    = in_data[c*N +: N];
            end
        end
    end

    // Output stage next state: a grant always fills; a FULL stage empties only when drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (grant_vld) state_d = FULL;
            FULL:  if (!grant_vld && out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Registered output word, round-robin pointer, error pulse and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_data    <= '0;
            out_channel <= '0;
            ptr         <= '0;
            sel_err     <= 1'b0;
            xfer_count  <= '0;
        end else begin
            state_q <= state_d;
            sel_err <= force_bad;
            if (out_valid && out_ready) begin
                xfer_count <= xfer_count + 16'd1;
            end
            if (grant_vld) begin
                out_data    <= sel_data;
                out_channel <= grant_idx;
                // Forced grants leave the pointer alone so fairness resumes where it stopped
                if (!force_en) begin
                    ptr <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_stream.sv
// tb/tb_rr_mux_stream.sv - self-checking bench for rr_mux_stream
module tb_rr_mux_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        force_en;
    logic [1:0]  force_sel;
    logic [7:0]  out_data;
    logic [1:0]  out_channel;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;
    logic [15:0] xfer_count;

    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic        b_force_en;
    logic [1:0]  b_force_sel;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_channel;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_sel_err;
    logic [15:0] b_xfer_count;

    rr_mux_stream #(.N(8), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .force_en(force_en), .force_sel(force_sel), .out_data(out_data),
        .out_channel(out_channel), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err), .xfer_count(xfer_count)
    );

    rr_mux_stream #(.N(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .force_en(b_force_en), .force_sel(b_force_sel), .out_data(b_out_data),
        .out_channel(b_out_channel), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sel_err(b_sel_err), .xfer_count(b_xfer_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model of the 4-channel instance
    bit         m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;
    int         m_count;

    function automatic int exp_grant();
        if (rst) return -1;
        if (m_valid && !out_ready) return -1;
        if (force_en) return in_valid[force_sel] ? int'(force_sel) : -1;
        for (int k = 0; k < 4; k++) begin
            if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = exp_grant();
        return (g < 0) ? 4'b0000 : 4'(1 << g);
    endfunction

    task automatic cycle();
        int         g;
        logic [7:0] d;
        bit         r, orr, f;
        g   = exp_grant();
        d   = (g >= 0) ? in_data[g*8 +: 8] : 8'h00;
        r   = rst;
        orr = out_ready;
        f   = force_en;
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_count = 0;
        end else begin
            if (m_valid && orr) m_count = (m_count + 1) % 65536;
            if (g >= 0) begin
                m_valid = 1; m_data = d; m_ch = g;
                if (!f) m_ptr = (g + 1) % 4;
            end else if (orr) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1; force_en = 1'b0;
        in_data = $urandom; b_in_valid = 3'b111;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_during: got %b want 0000", in_ready); end
        cycle(); cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (xfer_count !== 16'd0) begin errors++; $display("FAIL reset_xfer_count: got %0d want 0", xfer_count); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        checks++; if (b_out_valid !== 1'b0 || b_sel_err !== 1'b0) begin errors++; $display("FAIL reset_dut3: got valid=%b sel_err=%b want 0 0", b_out_valid, b_sel_err); end
        rst = 1'b0; b_in_valid = 3'b000;
    endtask

    task automatic test_round_robin();
        do_reset();
        in_data = 32'h44332211; in_valid = 4'hF; out_ready = 1'b1; force_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (in_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_in_ready[%0d]: got %b want %b", k, in_ready, 4'(1 << (k % 4))); end
            cycle();
            checks++; if (out_channel !== 2'(k % 4) || out_data !== 8'(8'h11 * (k % 4 + 1)) || out_valid !== 1'b1) begin
                errors++; $display("FAIL rr_out[%0d]: got ch=%0d data=%h v=%b want ch=%0d data=%h v=1", k, out_channel, out_data, out_valid, k % 4, 8'(8'h11 * (k % 4 + 1)));
            end
        end
        cycle();
        checks++; if (xfer_count !== 16'd8) begin errors++; $display("FAIL rr_xfer_count: got %0d want 8", xfer_count); end
    endtask

    task automatic test_skip_wrap();
        do_reset();
        in_valid = 4'b1010; out_ready = 1'b1; force_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (in_ready !== ((k % 2 == 0) ? 4'b0010 : 4'b1000)) begin errors++; $display("FAIL skip_in_ready[%0d]: got %b want %b", k, in_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000); end
            cycle();
            checks++; if (out_channel !== ((k % 2 == 0) ? 2'd1 : 2'd3)) begin errors++; $display("FAIL skip_channel[%0d]: got %0d want %0d", k, out_channel, (k % 2 == 0) ? 1 : 3); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] cnt;
        do_reset();
        in_data = 32'h44332211; in_valid = 4'hF; out_ready = 1'b1; force_en = 1'b0;
        cycle(); cycle();
        checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL bp_preload: got %h want 22", out_data); end
        cnt = xfer_count;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", k, in_ready); end
            cycle();
            checks++; if (out_data !== 8'h22 || out_channel !== 2'd1 || out_valid !== 1'b1 || xfer_count !== cnt) begin
                errors++; $display("FAIL bp_hold[%0d]: got data=%h ch=%0d v=%b cnt=%0d want 22 1 1 %0d", k, out_data, out_channel, out_valid, xfer_count, cnt);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
        cycle();
        checks++; if (out_channel !== 2'd2 || out_data !== 8'h33) begin errors++; $display("FAIL bp_release: got ch=%0d data=%h want 2 33", out_channel, out_data); end
    endtask

    task automatic test_forced();
        do_reset();
        in_data = 32'h44332211; in_valid = 4'hF; out_ready = 1'b1; force_en = 1'b0;
        cycle();
        force_en = 1'b1; force_sel = 2'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL force_ready[%0d]: got %b want 0100", k, in_ready); end
            cycle();
            checks++; if (out_channel !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL force_channel[%0d]: got ch=%0d v=%b want 2 1", k, out_channel, out_valid); end
        end
        force_en = 1'b0;
        cycle();
        checks++; if (out_channel !== 2'd1) begin errors++; $display("FAIL force_resume: got %0d want 1", out_channel); end
        force_en = 1'b1; force_sel = 2'd2; in_valid = 4'b1011;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL force_idle_ready: got %b want 0000", in_ready); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL force_idle_drop: got %b want 0", out_valid); end
        force_en = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            in_data   = $urandom;
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            force_en  = ($urandom_range(0, 4) == 0);
            force_sel = 2'($urandom);
            #1;
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", k, in_ready, exp_ready()); end
            cycle();
            checks++; if (out_valid !== m_valid || out_data !== m_data || out_channel !== 2'(m_ch) || xfer_count !== 16'(m_count) || sel_err !== 1'b0) begin
                errors++; $display("FAIL rand_out[%0d]: got v=%b d=%h ch=%0d cnt=%0d err=%b want v=%b d=%h ch=%0d cnt=%0d err=0",
                                   k, out_valid, out_data, out_channel, xfer_count, sel_err, m_valid, m_data, m_ch, m_count);
            end
        end
        force_en = 1'b0; in_valid = 4'h0; out_ready = 1'b1;
    endtask

    task automatic test_sel_err();
        do_reset();
        b_in_data = 24'h332211; b_force_en = 1'b1; b_force_sel = 2'd3; b_in_valid = 3'b111; b_out_ready = 1'b1;
        #1;
        checks++; if (b_in_ready !== 3'b000) begin errors++; $display("FAIL selerr_ready: got %b want 000", b_in_ready); end
        cycle();
        checks++; if (b_sel_err !== 1'b1 || b_out_valid !== 1'b0) begin errors++; $display("FAIL selerr_pulse: got err=%b v=%b want 1 0", b_sel_err, b_out_valid); end
        b_force_en = 1'b0;
        #1;
        checks++; if (b_in_ready !== 3'b001) begin errors++; $display("FAIL selerr_rr_ready: got %b want 001", b_in_ready); end
        cycle();
        checks++; if (b_sel_err !== 1'b0 || b_out_channel !== 2'd0 || b_out_data !== 8'h11) begin
            errors++; $display("FAIL selerr_clear: got err=%b ch=%0d d=%h want 0 0 11", b_sel_err, b_out_channel, b_out_data);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        b_force_en = 1'b0; b_in_valid = 3'b111; b_out_ready = 1'b1; in_valid = 4'h0;
        repeat (65536) cycle();
        checks++; if (b_xfer_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got %h want ffff", b_xfer_count); end
        cycle();
        checks++; if (b_xfer_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", b_xfer_count); end
        checks++; if (b_out_channel !== 2'd1) begin errors++; $display("FAIL wrap_channel: got %0d want 1", b_out_channel); end
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; force_en = 1'b0; force_sel = '0; out_ready = 1'b1;
        b_in_data = 24'h332211; b_in_valid = '0; b_force_en = 1'b0; b_force_sel = '0; b_out_ready = 1'b1;
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_count = 0;
        #1;
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_backpressure();
        test_forced();
        test_random();
        test_sel_err();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
